// File: rtl/binary_erosion_3x3.sv
// binary_erosion_3x3: streaming 3x3 binary erosion over a raster-scanned frame.
// Each accepted pixel completes the window centred one line and one column back.
// That centre pixel is emitted one cycle later. After the last input pixel, a
// flush phase drains the final line plus one pixel. Every flushed pixel sits on
// the bottom border or the last column, so the flush always outputs 0x00.
module binary_erosion_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eof
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int KMAX = NPIX + IMG_WIDTH;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT + 1);

    localparam logic [KW-1:0] K_FIRST_OUT = KW'(IMG_WIDTH + 1);
    localparam logic [KW-1:0] K_LAST_IN   = KW'(NPIX - 1);
    localparam logic [KW-1:0] K_FLUSH_END = KW'(KMAX);
    localparam logic [CW-1:0] COL_LAST    = CW'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [IMG_WIDTH-1:0] lb0_q;   // previous line, one bit per column
    logic [IMG_WIDTH-1:0] lb1_q;   // line before that
    logic [8:0]      win_q;        // 3 columns x {top, mid, bottom}, newest in [2:0]
    logic            out_valid_q;
    logic [7:0]      out_data_q;
    logic            out_sof_q;
    logic            out_eof_q;

    logic            in_ready_s;
    logic            accept_s;
    logic            restart_s;
    logic [KW-1:0]   cur_k_s;
    logic [CW-1:0]   cur_col_s;
    logic [RW-1:0]   cur_row_s;
    logic [2:0]      new_col_s;
    logic [8:0]      win_d;
    logic            emit_s;
    logic            border_s;
    logic            last_in_s;
    logic [6:0]      unused_data_s;

    assign unused_data_s = in_data[6:0];

    // Handshake and current-pixel position; an SOF accept restarts the frame at pixel 0.
    always_comb begin
        in_ready_s = 1'b0;
        if (!reset && (state_q != FLUSH)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s  = in_valid && in_ready_s;
        restart_s = accept_s && in_sof;
        if (restart_s) begin
            cur_k_s   = '0;
            cur_col_s = '0;
            cur_row_s = '0;
        end else begin
            cur_k_s   = k_q;
            cur_col_s = col_q;
            cur_row_s = row_q;
        end
    end

    // Window update and output decision for the pixel centred one line and one column back.
    always_comb begin
        new_col_s = {lb1_q[cur_col_s], lb0_q[cur_col_s], in_data[7]};
        if (accept_s) begin
            win_d = {win_q[5:0], new_col_s};
        end else begin
            win_d = win_q;
        end
        emit_s    = accept_s && (cur_k_s >= K_FIRST_OUT);
        last_in_s = accept_s && (cur_k_s == K_LAST_IN);
        // Input column 0/1 maps to output column W-1/0; input row <= 1 maps to output row 0.
        border_s  = (cur_col_s <= CW'(1)) || (cur_row_s <= RW'(1));
    end

    // Line buffers hold raw pixel bits; stale contents only ever feed border outputs.
    always_ff @(posedge pixel_clk) begin
        if (accept_s) begin
            lb1_q[cur_col_s] <= lb0_q[cur_col_s];
            lb0_q[cur_col_s] <= in_data[7];
        end else begin
            lb1_q <= lb1_q;
            lb0_q <= lb0_q;
        end
    end

    // Frame FSM, counters, window and registered output stage.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q     <= FILL;
            k_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            case (state_q)
                FLUSH: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= 8'h00;
                    out_sof_q   <= 1'b0;
                    out_eof_q   <= (k_q == K_FLUSH_END);
                    if (k_q == K_FLUSH_END) begin
                        state_q <= FILL;
                        k_q     <= '0;
                        col_q   <= '0;
                        row_q   <= '0;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                FILL, RUN: begin
                    out_valid_q <= emit_s;
                    out_data_q  <= (emit_s && !border_s && (&win_d)) ? 8'hFF : 8'h00;
                    out_sof_q   <= emit_s && (cur_k_s == K_FIRST_OUT);
                    out_eof_q   <= 1'b0;
                    if (accept_s) begin
                        k_q   <= cur_k_s + KW'(1);
                        win_q <= win_d;
                        if (cur_col_s == COL_LAST) begin
                            col_q <= '0;
                            row_q <= cur_row_s + RW'(1);
                        end else begin
                            col_q <= cur_col_s + CW'(1);
                            row_q <= cur_row_s;
                        end
                        if (last_in_s) begin
                            state_q <= FLUSH;
                        end else if (cur_k_s < K_FIRST_OUT) begin
                            state_q <= FILL;
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q     <= FILL;
                    k_q         <= '0;
                    col_q       <= '0;
                    row_q       <= '0;
                    out_valid_q <= 1'b0;
                    out_data_q  <= 8'h00;
                    out_sof_q   <= 1'b0;
                    out_eof_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_binary_erosion_3x3.sv
// Testbench for binary_erosion_3x3 on a 5x4 image, using a frame-level erosion model.
module tb_binary_erosion_3x3;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef struct {
        logic [7:0] d;
        bit         sof;
        bit         eof;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    binary_erosion_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .pixel_clk (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference erosion: border pixels are 0, otherwise AND of the 3x3 neighbourhood.
    function automatic bit erode_px(input bit [NPIX-1:0] img, input int r, input int c);
        bit all_one = 1'b1;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 1'b0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!img[(r + dr) * W + (c + dc)]) all_one = 1'b0;
        return all_one;
    endfunction

    // A full frame yields every output; a cut-short frame yields only outputs already complete.
    task automatic push_expected(input bit [NPIX-1:0] img, input int n_acc);
        int cnt;
        exp_t e;
        cnt = (n_acc >= NPIX) ? NPIX : ((n_acc > W + 1) ? n_acc - (W + 1) : 0);
        for (int p = 0; p < cnt; p++) begin
            e.d   = erode_px(img, p / W, p % W) ? 8'hFF : 8'h00;
            e.sof = (p == 0);
            e.eof = (p == NPIX - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_px(input bit b, input bit sof, input int gap_pct);
        int tries = 0;
        while ($urandom_range(99) < gap_pct && tries < 8) begin
            idle_cycle();
            tries++;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = {b, 7'($urandom)};
        tries    = 0;
        while (!in_ready && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 100) check("ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic send_frame(input bit [NPIX-1:0] img, input int n_acc, input int gap_pct,
                              input bit first_sof);
        push_expected(img, n_acc);
        for (int i = 0; i < n_acc; i++) send_px(img[i], (i == 0) && first_sof, gap_pct);
        idle_cycle();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);
    endtask

    // Single compare process: every output beat must match the next model entry.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.d);
                check("out_sof", out_sof, e.sof);
                check("out_eof", out_eof, e.eof);
            end
        end
    end

    bit [NPIX-1:0] ones_img;
    bit [NPIX-1:0] hole_img;
    bit [NPIX-1:0] rnd_img;
    int            n_low;
    int            n_ff;
    int            wait_cnt;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        ones_img = '1;
        hole_img = '1;
        hole_img[1 * W + 1] = 1'b0;

        // Hand-computed pins on the model itself.
        check("model_ones_1_1", erode_px(ones_img, 1, 1), 1);
        check("model_ones_2_3", erode_px(ones_img, 2, 3), 1);
        check("model_ones_0_0", erode_px(ones_img, 0, 0), 0);
        check("model_ones_3_2", erode_px(ones_img, 3, 2), 0);
        check("model_hole_1_3", erode_px(hole_img, 1, 3), 1);
        check("model_hole_2_3", erode_px(hole_img, 2, 3), 1);
        check("model_hole_1_2", erode_px(hole_img, 1, 2), 0);
        check("model_hole_2_2", erode_px(hole_img, 2, 2), 0);
        n_ff = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) n_ff += erode_px(ones_img, r, c);
        check("model_ones_count", n_ff, 6);

        do_reset(3);

        // Frame A: all ones, continuous; latency, ready and flush timing.
        push_expected(ones_img, NPIX);
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sof   = (k == 0);
            in_data  = 8'hFF;
            check("ready_in_frame", in_ready, 1);
            if (k > 0) check("latency_valid", out_valid, (k - 1 >= W + 1) ? 1 : 0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        n_low    = 0;
        while (!in_ready && n_low < 50) begin
            check("flush_valid", out_valid, 1);
            n_low++;
            @(negedge clk);
        end
        check("flush_ready_low_cycles", n_low, W + 1);
        check("eof_after_flush", out_eof, 1);

        // Frame B: hole at (1,1), pixel 0 sent without in_sof.
        send_frame(hole_img, NPIX, 0, 1'b0);

        // Frame C: random bits with roughly 50% input gaps.
        for (int i = 0; i < NPIX; i++) rnd_img[i] = 1'($urandom_range(1));
        send_frame(rnd_img, NPIX, 50, 1'b1);

        // Frame D aborted by SOF after 9 accepts; frame E replaces it.
        for (int i = 0; i < NPIX; i++) rnd_img[i] = 1'($urandom_range(1));
        push_expected(rnd_img, 9);
        for (int i = 0; i < 9; i++) send_px(rnd_img[i], i == 0, 0);
        send_frame(ones_img, NPIX, 0, 1'b1);

        // Reset mid-frame after 12 accepts, then a clean all-ones frame.
        for (int i = 0; i < NPIX; i++) rnd_img[i] = 1'($urandom_range(1));
        push_expected(rnd_img, 12);
        for (int i = 0; i < 12; i++) send_px(rnd_img[i], i == 0, 0);
        idle_cycle();
        idle_cycle();
        do_reset(2);
        send_frame(ones_img, NPIX, 30, 1'b1);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        repeat (10) @(negedge clk);
        check("all_outputs_seen", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_erosion_3x3.md
BINARY_EROSION_3X3 -- requirements
Module: binary_erosion_3x3

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame.
REQ-003 The block SHALL have port pixel_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 The block SHALL have port in_sof, input, 1 bit: qualified by in_valid; marks pixel (0,0) of a frame.
REQ-008 The block SHALL have port in_data, input, 8 bits: binarized pixel; only bit 7 is used (1 = foreground).
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data is valid this cycle.
REQ-010 The block SHALL have port out_data, output, 8 bits: eroded pixel, 0xFF or 0x00 only.
REQ-011 The block SHALL have port out_sof, output, 1 bit: high with output pixel (0,0).
REQ-012 The block SHALL have port out_eof, output, 1 bit: high with output pixel (IMG_HEIGHT-1, IMG_WIDTH-1).

Function
REQ-013 Accept rule: an input is accepted when in_valid and in_ready are both high in the same cycle; with in_ready low, input is ignored. The output has no backpressure.
REQ-014 Erosion rule: out_data for pixel (r,c) SHALL be 0xFF iff bit 7 of all 9 inputs in rows r-1..r+1 and columns c-1..c+1 is 1; otherwise 0x00.
REQ-015 Border rule: pixels with r=0, r=IMG_HEIGHT-1, c=0 or c=IMG_WIDTH-1 SHALL output 0x00.
REQ-016 Storage: two IMG_WIDTH x 1-bit line buffers plus a 3x3 window register.
REQ-017 Counters: column counter wraps IMG_WIDTH-1 -> 0 and increments the row counter; the frame is complete at accepted-pixel count IMG_WIDTH*IMG_HEIGHT.
REQ-018 The FSM SHALL have three states: FILL, RUN, FLUSH.
REQ-019 FILL: the first IMG_WIDTH+1 accepted inputs of a frame SHALL produce no output; the next accept moves the FSM to RUN.
REQ-020 RUN: each accepted input k (counted from 0) SHALL produce output pixel k-(IMG_WIDTH+1) on out_valid exactly 1 cycle later (registered).
REQ-021 RUN -> FLUSH on accept of input IMG_WIDTH*IMG_HEIGHT-1.
REQ-022 FLUSH: in_ready=0; the block SHALL emit the remaining IMG_WIDTH+1 outputs on consecutive cycles, with missing inputs padded as 0.
REQ-023 FLUSH: the last flush output SHALL carry out_eof; the FSM then returns to FILL with all counters at 0.
REQ-024 in_ready SHALL be 1 in FILL and RUN, and 0 in FLUSH and during reset.
REQ-025 Each frame SHALL emit exactly IMG_WIDTH*IMG_HEIGHT outputs in row-major order; out_sof and out_eof SHALL each be high exactly once per frame.
REQ-026 An accepted input with in_sof=1 in FILL or RUN SHALL abort the current frame: counters restart, no further outputs from the old frame, and that pixel becomes pixel 0 of the new frame.
REQ-027 An accepted input with in_sof=0 at count 0 SHALL still be treated as pixel 0.
REQ-028 out_valid SHALL be 0 between accepts in RUN; gaps in in_valid SHALL not corrupt the window or line buffers.

Reset
REQ-029 While reset=1 the block SHALL force: out_valid=0, out_data=0x00, out_sof=0, out_eof=0, in_ready=0, FSM=FILL, counters=0.
REQ-030 Line buffer contents need not be cleared; border and fill logic SHALL guarantee no stale data reaches out_data.
REQ-031 Reset asserted mid-frame or mid-FLUSH SHALL abandon that frame with no further outputs from it.
REQ-032 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-033 IMG_WIDTH=4, IMG_HEIGHT=3, all inputs 0xFF -> 12 outputs; only (1,1) and (1,2) are 0xFF; out_sof on output 0, out_eof on output 11.
REQ-034 IMG_WIDTH=5, IMG_HEIGHT=4, all 0xFF except 0x00 at (1,1) -> 0xFF only at (1,3) and (2,3); all other outputs 0x00.
REQ-035 Defaults, continuous in_valid -> first out_valid occurs the cycle after the 642nd accept; after the 307200th accept, in_ready=0 for exactly 641 cycles with out_valid=1 on each, and out_eof on the last.
REQ-036 Random in_valid gaps (~50% duty), IMG_WIDTH=8, IMG_HEIGHT=6, random bits -> out_data matches the reference model pixel-for-pixel, with 48 outputs per frame.
REQ-037 Reset pulse after 20 accepts, then a new 4x3 all-0xFF frame -> output identical to REQ-033, with no extra out_valid.
REQ-038 in_sof re-asserted at accept 7 of a 4x3 frame -> old frame emits no more outputs; the new frame produces the REQ-033 result.
